// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, single-cycle-latency IMEM interface and IF/ID register.
// Define IF_SKID_EN to keep an in-flight response across a stall instead of rewinding the PC.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
`ifdef IF_SKID_EN
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_inst_q, skid_inst_d;
`endif

   assign im_req   = (state_q != StBoot) && !stall_i;
   assign im_addr  = pc_q;
   assign id_valid = id_valid_q;
   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = 1'b0;
      pend_pc_d  = pend_pc_q;
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
`ifdef IF_SKID_EN
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_inst_d  = skid_inst_q;
`endif

      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   if (stall_i) state_d = StHold;
         StHold:  if (!stall_i) state_d = StRun;
         default: state_d = StBoot;
      endcase

      if (im_req) begin
         pc_d      = pc_q + 32'd4;
         pend_d    = 1'b1;
         pend_pc_d = pc_q;
      end

      if (!stall_i) begin
`ifdef IF_SKID_EN
         if (skid_valid_q) begin
            id_valid_d   = 1'b1;
            id_pc_d      = skid_pc_q;
            id_inst_d    = skid_inst_q;
            skid_valid_d = 1'b0;
         end else
`endif
         if (pend_q) begin
            id_valid_d = 1'b1;
            id_pc_d    = pend_pc_q;
            id_inst_d  = im_rdata;
         end else begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
         end
      end else if (pend_q) begin
         // Response arrives while IF/ID is frozen: park it, or rewind and refetch later.
`ifdef IF_SKID_EN
         skid_valid_d = 1'b1;
         skid_pc_d    = pend_pc_q;
         skid_inst_d  = im_rdata;
`else
         pc_d = pend_pc_q;
`endif
      end

      if (redirect_i) begin
         state_d    = StRun;
         pc_d       = redirect_pc_i & ~32'h0000_0003;
         pend_d     = 1'b0;
         id_valid_d = 1'b0;
         id_inst_d  = NOP_INST;
`ifdef IF_SKID_EN
         skid_valid_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         pend_q     <= 1'b0;
         pend_pc_q  <= RESET_PC;
         id_valid_q <= 1'b0;
         id_pc_q    <= RESET_PC;
         id_inst_q  <= NOP_INST;
`ifdef IF_SKID_EN
         skid_valid_q <= 1'b0;
         skid_pc_q    <= RESET_PC;
         skid_inst_q  <= NOP_INST;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
`ifdef IF_SKID_EN
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_inst_q  <= skid_inst_d;
`endif
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/redirect traffic, scoreboarded
// against the expected in-order PC stream with restart points queued by the driver.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        im_req;
   logic [31:0] im_addr;
   logic [31:0] im_rdata = 32'd0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .im_req       (im_req),
      .im_addr      (im_addr),
      .im_rdata     (im_rdata),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_inst      (id_inst)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          deliveries = 0;
   logic [31:0] restart_q[$];
   logic [31:0] exp_next = RESET_PC;

   // Memory image: word i holds i.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Memory responder and scoreboard monitor.
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc = 32'd0;
   logic [31:0] prev_inst = 32'd0;
   always @(posedge clk) begin : mon
      logic        st, rd, rq;
      logic [31:0] ad;
      st = stall_i;
      rd = redirect_i;
      rq = im_req;
      ad = im_addr;
      #1;
      im_rdata = rq ? mem(ad) : $urandom;
      if (rst) begin
         exp_next = RESET_PC;
      end else if (rd) begin
         chk1("restart_queue_nonempty", restart_q.size() != 0, 1'b1);
         if (restart_q.size() != 0) exp_next = restart_q.pop_front();
         chk1("redirect_kill_valid", id_valid, 1'b0);
         chk("redirect_kill_inst", id_inst, NOP);
      end else if (st) begin
         chk1("stall_hold_valid", id_valid, prev_valid);
         chk("stall_hold_pc", id_pc, prev_pc);
         chk("stall_hold_inst", id_inst, prev_inst);
      end else if (id_valid) begin
         chk("stream_pc", id_pc, exp_next);
         chk("stream_inst", id_inst, mem(exp_next));
         exp_next = exp_next + 32'd4;
         deliveries++;
      end else begin
         chk("bubble_nop", id_inst, NOP);
      end
      if (!rst) begin
         chk1("addr_aligned", im_addr[1:0] == 2'b00, 1'b1);
         if (stall_i) chk1("no_req_in_stall", im_req, 1'b0);
      end
      prev_valid = id_valid;
      prev_pc    = id_pc;
      prev_inst  = id_inst;
   end

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_im_req"}, im_req, 1'b0);
      chk({tag, "_im_addr"}, im_addr, RESET_PC);
      chk1({tag, "_id_valid"}, id_valid, 1'b0);
      chk({tag, "_id_pc"}, id_pc, RESET_PC);
      chk({tag, "_id_inst"}, id_inst, NOP);
   endtask

   task automatic redirect_to(input logic [31:0] t);
      redirect_i    = 1'b1;
      redirect_pc_i = t;
      restart_q.push_back(t & ~32'h0000_0003);
   endtask

   task automatic wait_valid(input int budget, output logic ok, output int gap);
      ok  = 1'b0;
      gap = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (id_valid) ok = 1'b1;
         else gap++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ok;
      int          gap;
      logic [31:0] t;

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");

      // Boot sequence from reset release.
      rst = 1'b0;
      #1 chk1("boot_no_req", im_req, 1'b0);
      @(negedge clk);
      chk1("c1_req", im_req, 1'b1);
      chk("c1_addr", im_addr, 32'h0);
      @(negedge clk);
      chk("c2_addr", im_addr, 32'h4);
      @(negedge clk);
      chk("c3_addr", im_addr, 32'h8);
      chk1("c3_valid", id_valid, 1'b1);
      chk("c3_pc", id_pc, 32'h0);
      chk("c3_inst", id_inst, 32'h0);

      // Three-cycle stall while id_pc = 0x10.
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (id_valid && id_pc == 32'h10) ok = 1'b1;
      end
      chk1("reach_pc_10", ok, 1'b1);
      stall_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_pc_held", id_pc, 32'h10);
         chk1("stall_req_low", im_req, 1'b0);
      end
      stall_i = 1'b0;
      wait_valid(6, ok, gap);
      chk1("after_stall_valid", ok, 1'b1);
      chk("after_stall_pc", id_pc, 32'h14);
`ifdef IF_SKID_EN
      chk("skid_gap", gap, 32'd0);
`else
      chk1("refetch_gap", gap >= 1 && gap <= 2, 1'b1);
`endif

      // Redirect wins over a simultaneous stall; low bits of the target are dropped.
      @(negedge clk);
      stall_i = 1'b1;
      redirect_to(32'h0000_0103);
      @(negedge clk);
      chk("redir_addr", im_addr, 32'h100);
      chk1("redir_valid", id_valid, 1'b0);
      chk("redir_inst", id_inst, NOP);
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      #1 chk1("redir_req", im_req, 1'b1);
      repeat (2) @(negedge clk);
      chk1("redir_target_valid", id_valid, 1'b1);
      chk("redir_target_pc", id_pc, 32'h100);
      chk("redir_target_inst", id_inst, mem(32'h100));

      // PC wrap at the top of the address space.
      redirect_to(32'hFFFF_FFFC);
      @(negedge clk);
      redirect_i = 1'b0;
      chk("wrap_addr_top", im_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_addr_zero", im_addr, 32'h0);
      @(negedge clk);
      chk("wrap_id_top", id_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_id_zero", id_pc, 32'h0);
      chk("wrap_inst_zero", id_inst, 32'h0);

      // Asynchronous reset with a response parked in HOLD.
      repeat (4) @(negedge clk);
      stall_i = 1'b1;
      @(negedge clk);
      #2;
      rst     = 1'b1;
      stall_i = 1'b0;
      #1 chk_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      wait_valid(8, ok, gap);
      chk1("midrst_valid", ok, 1'b1);
      chk("midrst_first_pc", id_pc, RESET_PC);
      chk("midrst_first_inst", id_inst, mem(RESET_PC));

      // Redirect during the boot cycle replaces RESET_PC.
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      redirect_to(32'h0000_0200);
      @(negedge clk);
      redirect_i = 1'b0;
      chk("boot_redir_addr", im_addr, 32'h200);
      chk1("boot_redir_req", im_req, 1'b1);
      wait_valid(6, ok, gap);
      chk1("boot_redir_valid", ok, 1'b1);
      chk("boot_redir_pc", id_pc, 32'h200);

      // Random stall/redirect traffic; the monitor does the checking.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         stall_i = ($urandom % 4) == 0;
         if (($urandom % 12) == 0) begin
            t = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            redirect_to(t);
         end else begin
            redirect_i = 1'b0;
         end
      end
      @(negedge clk);
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      repeat (10) @(negedge clk);
      chk1("random_progress", deliveries > 80, 1'b1);
      chk("restart_queue_drained", restart_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
